// File: rtl/note_distributor.sv
// Buffers one note from the song reader and hands it to a free note player,
// picked round-robin; rests are swallowed and notes that wait too long are dropped.
module note_distributor #(
  parameter int NUM_PLAYERS = 3,
  parameter int DROP_BEATS  = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               play_enable,
  input  logic                               beat,
  input  logic [5:0]                         note_in,
  input  logic [5:0]                         duration_in,
  input  logic                               note_valid,
  output logic                               note_ready,
  input  logic [NUM_PLAYERS-1:0]             playing,
  output logic [NUM_PLAYERS-1:0]             load_new_note,
  output logic [5:0]                         note_out,
  output logic [5:0]                         duration_out,
  output logic                               dropped,
  output logic [$clog2(NUM_PLAYERS+1)-1:0]   active_count
);

  localparam int PW = $clog2(NUM_PLAYERS);
  localparam int CW = $clog2(NUM_PLAYERS+1);
  localparam int WW = (DROP_BEATS > 0) ? $clog2(DROP_BEATS+1) : 1;

  function automatic logic [CW-1:0] popcount(input logic [NUM_PLAYERS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  logic                   buf_valid;
  logic [5:0]             buf_note;
  logic [5:0]             buf_dur;
  logic [PW-1:0]          ptr;
  logic [WW-1:0]          wait_cnt;
  logic [NUM_PLAYERS-1:0] load_p1;
  logic [NUM_PLAYERS-1:0] cand;
  logic                   found;
  logic [PW-1:0]          sel_idx;
  logic [PW-1:0]          ptr_next;
  logic                   wait_last;

  assign note_ready = ~buf_valid & play_enable & ~reset;
  assign wait_last  = (DROP_BEATS > 0) && ((int'(wait_cnt) + 1) >= DROP_BEATS);

  // A player stays excluded while its playing flag has not yet caught up with its load.
  always_comb begin
    int         idx;
    logic [PW-1:0] cur;
    cand    = ~playing & ~(load_new_note | load_p1);
    found   = 1'b0;
    sel_idx = '0;
    idx     = 0;
    cur     = '0;
    for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_PLAYERS) idx = idx - NUM_PLAYERS;
      cur = PW'(idx);
      if (cand[cur]) begin
        found   = 1'b1;
        sel_idx = cur;
      end
    end
    ptr_next = (int'(sel_idx) == NUM_PLAYERS - 1) ? '0 : sel_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    active_count  <= popcount(playing);
    load_new_note <= '0;
    dropped       <= 1'b0;
    load_p1       <= load_new_note;
    if (reset) begin
      buf_valid     <= 1'b0;
      ptr           <= '0;
      wait_cnt      <= '0;
      load_p1       <= '0;
      note_out      <= '0;
      duration_out  <= '0;
      active_count  <= '0;
    end else if (play_enable) begin
      if (!buf_valid) begin
        if (note_valid) begin
          buf_valid <= 1'b1;
          buf_note  <= note_in;
          buf_dur   <= duration_in;
          wait_cnt  <= '0;
        end
      end else if (buf_note == 6'd0) begin
        buf_valid <= 1'b0;
      end else if (found) begin
        load_new_note <= NUM_PLAYERS'(1) << sel_idx;
        note_out      <= buf_note;
        duration_out  <= buf_dur;
        buf_valid     <= 1'b0;
        ptr           <= ptr_next;
        wait_cnt      <= '0;
      end else if (beat && (DROP_BEATS > 0)) begin
        if (wait_last) begin
          buf_valid <= 1'b0;
          dropped   <= 1'b1;
          wait_cnt  <= '0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_note_distributor.sv
// Scoreboard bench for note_distributor: expected loads/drops are queued when
// stimulus is driven and matched against the DUT's strobes as they appear.
module tb_note_distributor;
  localparam int NP = 3;
  localparam int CW = $clog2(NP+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          play_enable = 1'b1;
  logic          beat = 1'b0;
  logic [5:0]    note_in = '0;
  logic [5:0]    duration_in = '0;
  logic          note_valid = 1'b0;
  logic          note_ready;
  logic [NP-1:0] playing;
  logic [NP-1:0] load_new_note;
  logic [5:0]    note_out;
  logic [5:0]    duration_out;
  logic          dropped;
  logic [CW-1:0] active_count;

  logic [NP-1:0] play_base = '0;
  logic [NP-1:0] auto_bits = '0;
  logic [NP-1:0] pend = '0;
  logic          auto_en = 1'b0;
  assign playing = auto_en ? auto_bits : play_base;

  note_distributor #(.NUM_PLAYERS(NP), .DROP_BEATS(4)) dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .beat(beat),
    .note_in(note_in), .duration_in(duration_in), .note_valid(note_valid),
    .note_ready(note_ready), .playing(playing), .load_new_note(load_new_note),
    .note_out(note_out), .duration_out(duration_out), .dropped(dropped),
    .active_count(active_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_drop;
    logic [NP-1:0] mask;
    logic [5:0]    note;
    logic [5:0]    dur;
    int            cyc;
  } ev_t;
  ev_t sb[$];
  ev_t e;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic expect_load(input logic [NP-1:0] m, input logic [5:0] n, input logic [5:0] d, input int c);
    ev_t x;
    x.is_drop = 1'b0; x.mask = m; x.note = n; x.dur = d; x.cyc = c;
    sb.push_back(x);
  endtask

  task automatic expect_drop(input int c);
    ev_t x;
    x.is_drop = 1'b1; x.mask = '0; x.note = '0; x.dur = '0; x.cyc = c;
    sb.push_back(x);
  endtask

  // Monitor: also models players raising their playing flag one cycle after a load.
  always @(negedge clk) begin
    if (!auto_en) begin
      auto_bits = '0;
      pend = '0;
    end else begin
      auto_bits = auto_bits | pend;
      pend = load_new_note;
    end
    if (load_new_note != '0 || dropped) begin
      if (sb.size() == 0) begin
        check_val("unexpected_event", {dropped, load_new_note}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("drop_flag", dropped, e.is_drop);
        check_val("load_mask", load_new_note, e.mask);
        if (!e.is_drop) begin
          check_val("note_out", note_out, e.note);
          check_val("duration_out", duration_out, e.dur);
        end
        check_val("event_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send_note(input logic [5:0] n, input logic [5:0] d, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    while (!note_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!note_ready) begin
      check_val("accept_timeout", 32'd0, 32'd1);
      acc = -100;
      return;
    end
    note_valid = 1'b1; note_in = n; duration_in = d;
    @(posedge clk); #1;
    acc = cyc;
    note_valid = 1'b0;
  endtask

  task automatic pulse_beat();
    @(negedge clk);
    beat = 1'b1;
    @(posedge clk); #1;
    beat = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 30) begin
      @(negedge clk);
      t++;
    end
    check_val(tag, sb.size(), 32'd0);
    idle(3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int acc;
    int acc_b;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", note_ready, 32'd0);
    check_val("rst_load", load_new_note, 32'd0);
    check_val("rst_note", note_out, 32'd0);
    check_val("rst_dur", duration_out, 32'd0);
    check_val("rst_dropped", dropped, 32'd0);
    check_val("rst_active", active_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("ready_after_rst", note_ready, 32'd1);

    // Single note into an idle bank
    send_note(6'd20, 6'd12, acc);
    expect_load(3'b001, 6'd20, 6'd12, acc + 1);
    check_val("ready_in_seek", note_ready, 32'd0);
    @(posedge clk); #1;
    check_val("ready_in_load", note_ready, 32'd1);
    @(posedge clk); #1;
    check_val("note_hold", note_out, 32'd20);
    check_val("dur_hold", duration_out, 32'd12);
    check_val("load_cleared", load_new_note, 32'd0);
    drain("sb_single");

    // Back-to-back notes with players going busy, then wait for player 1 to free
    do_reset();
    auto_en = 1'b1;
    send_note(6'd10, 6'd1, acc);
    expect_load(3'b001, 6'd10, 6'd1, acc + 1);
    send_note(6'd11, 6'd2, acc);
    expect_load(3'b010, 6'd11, 6'd2, acc + 1);
    send_note(6'd12, 6'd3, acc);
    expect_load(3'b100, 6'd12, 6'd3, acc + 1);
    send_note(6'd13, 6'd4, acc);
    idle(4);
    check_val("all_busy_count", active_count, 32'd3);
    @(negedge clk);
    play_base = 3'b101;
    auto_en = 1'b0;
    expect_load(3'b010, 6'd13, 6'd4, cyc + 1);
    drain("sb_rr");

    // Rest is consumed without a load
    play_base = '0;
    send_note(6'd0, 6'd5, acc);
    check_val("rest_ready_seek", note_ready, 32'd0);
    @(posedge clk); #1;
    check_val("rest_ready_back", note_ready, 32'd1);
    idle(4);
    drain("sb_rest");

    // Drop after four beats with every player busy
    do_reset();
    play_base = 3'b111;
    send_note(6'd30, 6'd7, acc);
    repeat (3) pulse_beat();
    @(negedge clk);
    beat = 1'b1;
    expect_drop(cyc + 1);
    @(posedge clk); #1;
    beat = 1'b0;
    check_val("ready_after_drop", note_ready, 32'd1);
    drain("sb_drop");

    // Player 2 frees in the same cycle as the final beat: load wins
    send_note(6'd31, 6'd8, acc);
    repeat (3) pulse_beat();
    @(negedge clk);
    beat = 1'b1;
    play_base = 3'b011;
    expect_load(3'b100, 6'd31, 6'd8, cyc + 1);
    @(posedge clk); #1;
    beat = 1'b0;
    drain("sb_late_free");

    // Pause while a free player is available
    do_reset();
    play_base = '0;
    send_note(6'd40, 6'd9, acc);
    play_enable = 1'b0;
    repeat (5) pulse_beat();
    check_val("ready_paused", note_ready, 32'd0);
    @(negedge clk);
    play_enable = 1'b1;
    expect_load(3'b001, 6'd40, 6'd9, cyc + 1);
    drain("sb_pause");

    // Reset with a note buffered
    play_base = 3'b111;
    send_note(6'd50, 6'd3, acc);
    idle(2);
    check_val("busy_count", active_count, 32'd3);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("mid_rst_load", load_new_note, 32'd0);
    check_val("mid_rst_note", note_out, 32'd0);
    check_val("mid_rst_dur", duration_out, 32'd0);
    check_val("mid_rst_dropped", dropped, 32'd0);
    check_val("mid_rst_active", active_count, 32'd0);
    check_val("mid_rst_ready", note_ready, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    play_base = '0;
    send_note(6'd51, 6'd4, acc);
    expect_load(3'b001, 6'd51, 6'd4, acc + 1);
    drain("sb_reset");

    // Only player 0 free and its flag never rises: exclusion delays the reload
    do_reset();
    play_base = 3'b110;
    send_note(6'd60, 6'd1, acc);
    expect_load(3'b001, 6'd60, 6'd1, acc + 1);
    send_note(6'd61, 6'd2, acc_b);
    expect_load(3'b001, 6'd61, 6'd2, acc_b + 2);
    drain("sb_exclude");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/note_distributor.md
Name: note_distributor

Overview:
- Sits between the song reader and the bank of note players.
- Accepts one note/duration pair at a time over a valid/ready handshake and buffers it.
- Loads the buffered note into a free player, chosen round-robin from the players' playing flags, by pulsing that player's load_new_note.
- Rests (note 0) are consumed without loading any player. A note that finds no free player within DROP_BEATS beats is discarded and flagged.

Parameters:
NUM_PLAYERS, 3, number of note players driven; legal range 2..8.
DROP_BEATS, 4, beats a buffered note may wait for a free player before it is discarded; 0 = wait forever.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
play_enable  input  1  high = run; low = freeze all state
beat  input  1  1/48 s single-cycle strobe
note_in  input  6  note from the song reader; 0 = rest
duration_in  input  6  duration in beats
note_valid  input  1  note_in/duration_in are valid
note_ready  output  1  distributor can accept a note this cycle
playing  input  NUM_PLAYERS  per-player busy flags from the note players
load_new_note  output  NUM_PLAYERS  one-hot, single-cycle load strobe
note_out  output  6  note for the player being loaded
duration_out  output  6  duration for the player being loaded
dropped  output  1  single-cycle pulse when a note is discarded
active_count  output  $clog2(NUM_PLAYERS+1)  registered popcount of playing

Behaviour:
- Reset values: note_ready=0 during reset and 1 after. load_new_note=0, note_out=0, duration_out=0, dropped=0, active_count=0. Reset also clears the buffer, the round-robin pointer (=0), the wait counter and the exclude mask.
- Buffer (one entry): note_ready = ~buf_valid & play_enable & ~reset.
  - On the edge where note_valid & note_ready, buf_note/buf_dur capture note_in/duration_in and buf_valid is set.
  - Inputs are ignored when note_ready is low.
- States:
  - EMPTY (buf_valid=0).
  - SEEK (buf_valid=1, searching).
  - LOAD (one cycle; outputs asserted).
- SEEK with play_enable=1 and buf_note==0 (rest):
  - buf_valid clears on the next edge; no load, no dropped; go to EMPTY.
  - Rest latency: accept edge + 1 clock.
- SEEK with play_enable=1 and buf_note!=0:
  - Candidate set = ~playing & ~exclude.
  - Search starts at index ptr and wraps modulo NUM_PLAYERS.
  - If a candidate exists, on the next edge:
    - load_new_note[i]=1, note_out=buf_note, duration_out=buf_dur (all registered).
    - buf_valid=0, ptr=(i+1) mod NUM_PLAYERS, wait counter cleared, state LOAD.
  - Load latency: load_new_note is high in the 2nd cycle after the accepting edge.
- LOAD: outputs held exactly one cycle, then load_new_note=0. note_out/duration_out keep their last values.
  - The next note may be accepted during the LOAD cycle (note_ready=1).
- Exclude mask:
  - A player is excluded from allocation in the cycle its load_new_note is high and in the following cycle.
  - This covers the one-cycle lag before its playing flag rises.
  - A player is never loaded twice within 2 cycles.
- Wait/drop: in SEEK with no candidate, the wait counter increments on each beat.
  - If DROP_BEATS>0 and the counter reaches DROP_BEATS, then on that edge: buffer cleared, dropped=1 for one cycle, counter=0, go to EMPTY.
  - If a candidate appears in the same cycle as the final beat, the load wins and there is no drop.
- play_enable=0:
  - No accepts, no loads, no drops.
  - The counter ignores beat.
  - Buffer and ptr are held; any LOAD pulse already registered still completes.
  - Operation resumes from the held state when play_enable returns high.
- Reset mid-operation: the buffered note is lost silently (no dropped pulse). Any load_new_note pulse is forced to 0 in the next cycle.
- active_count: popcount(playing) registered every clock; it is not gated by play_enable.
- Only one load per cycle; at most one note in flight.

Test Plan:
- Reset, then note_valid with note=20, dur=12, all playing=0 -> load_new_note=3'b001 exactly 2 cycles after the accept edge, note_out=20, duration_out=12, note_ready high again in the LOAD cycle.
- Three back-to-back notes (10, 11, 12), with playing bits set by the bench one cycle after each load -> loads on players 0, 1, 2 in order; the 4th note (13) after player 1 frees -> loaded on player 1; ptr wraps correctly.
- note=0, dur=5 -> no load_new_note, no dropped, note_ready returns 1 one cycle after accept.
- All playing=3'b111, note=30, DROP_BEATS=4 -> dropped pulses for 1 cycle on the 4th beat, buffer empties, no load; repeat with playing[2] falling on the 4th beat's cycle -> load on player 2, no drop.
- Deassert play_enable while in SEEK with a free player -> no load while low; reassert -> load 1 cycle later with the original note/duration.
- Assert reset while buf_valid=1 -> next cycle all outputs 0, dropped=0, active_count=0; a following note is loaded on player 0.
